// File: rtl/m_dmw_buf.sv
// M-stage store path: AdES check, word-bus alignment and a 2-entry write buffer toward the bridge.
// Latency 1 cycle through the buffer; with DMW_BYPASS_EN an empty buffer forwards a ready store in the same cycle.
// Backpressure: bus_wready low holds the head entry; stall rises only when the buffer is full and nothing pops.
module m_dmw_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  DMWop,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    input  logic        bus_wready,
    output logic        AdES,
    output logic        stall,
    output logic        bus_wvalid,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        empty
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t      state;
    logic        hd_vld;
    logic [31:0] hd_addr, hd_data, tl_addr, tl_data;
    logic [3:0]  hd_be, tl_be;

    logic        is_sw, is_sh, is_sb, is_st;
    logic        in_dm, in_t0, in_t1, in_int, cnt_reg, legal;
    logic        req, buf_pop, push;
    logic [31:0] al_addr, al_data;
    logic [3:0]  al_be;

    assign is_sw = (DMWop == 3'd1);
    assign is_sh = (DMWop == 3'd2);
    assign is_sb = (DMWop == 3'd3);
    assign is_st = is_sw | is_sh | is_sb;

    assign in_dm   = (addr <= 32'h0000_2fff);
    assign in_t0   = (addr >= 32'h0000_7f00) && (addr <= 32'h0000_7f0b);
    assign in_t1   = (addr >= 32'h0000_7f10) && (addr <= 32'h0000_7f1b);
    assign in_int  = (addr >= 32'h0000_7f20) && (addr <= 32'h0000_7f23);
    assign cnt_reg = ((addr >= 32'h0000_7f08) && (addr <= 32'h0000_7f0b)) ||
                     ((addr >= 32'h0000_7f18) && (addr <= 32'h0000_7f1b));
    assign legal   = in_dm | in_t0 | in_t1 | in_int;

    assign AdES = is_st && ((is_sw && (addr[1:0] != 2'b00)) ||
                            (is_sh && addr[0]) ||
                            ((is_sh || is_sb) && (in_t0 || in_t1)) ||
                            cnt_reg || !legal);

    assign req = is_st && !AdES && !flush;

    always_comb begin
        al_addr = {addr[31:2], 2'b00};
        al_data = wdata;
        al_be   = 4'b1111;
        if (is_sh) begin
            al_data = {2{wdata[15:0]}};
            al_be   = addr[1] ? 4'b1100 : 4'b0011;
        end else if (is_sb) begin
            al_data = {4{wdata[7:0]}};
            al_be   = 4'b0001 << addr[1:0];
        end
    end

    assign buf_pop = hd_vld && bus_wready;

`ifdef DMW_BYPASS_EN
    logic byp;
    // An empty buffer with a ready bridge hands the store straight through.
    assign byp        = (state == EMPTY) && req && bus_wready;
    assign push       = req && !byp && ((state != FULL) || buf_pop);
    assign bus_wvalid = byp | hd_vld;
    assign bus_addr   = byp ? al_addr : hd_addr;
    assign bus_wdata  = byp ? al_data : hd_data;
    assign bus_be     = byp ? al_be   : hd_be;
`else
    assign push       = req && ((state != FULL) || buf_pop);
    assign bus_wvalid = hd_vld;
    assign bus_addr   = hd_addr;
    assign bus_wdata  = hd_data;
    assign bus_be     = hd_be;
`endif

    assign stall = req && (state == FULL) && !buf_pop;

    // Head entry lives in the bus output registers; tail shifts forward on pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= EMPTY;
            hd_vld  <= 1'b0;
            hd_addr <= 32'h0;
            hd_data <= 32'h0;
            hd_be   <= 4'h0;
            tl_addr <= 32'h0;
            tl_data <= 32'h0;
            tl_be   <= 4'h0;
            empty   <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        hd_addr <= al_addr;
                        hd_data <= al_data;
                        hd_be   <= al_be;
                        hd_vld  <= 1'b1;
                        empty   <= 1'b0;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    case ({push, buf_pop})
                        2'b11: begin
                            hd_addr <= al_addr;
                            hd_data <= al_data;
                            hd_be   <= al_be;
                        end
                        2'b10: begin
                            tl_addr <= al_addr;
                            tl_data <= al_data;
                            tl_be   <= al_be;
                            state   <= FULL;
                        end
                        2'b01: begin
                            hd_vld <= 1'b0;
                            empty  <= 1'b1;
                            state  <= EMPTY;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (buf_pop) begin
                        hd_addr <= tl_addr;
                        hd_data <= tl_data;
                        hd_be   <= tl_be;
                        if (push) begin
                            tl_addr <= al_addr;
                            tl_data <= al_data;
                            tl_be   <= al_be;
                        end else begin
                            state <= ONE;
                        end
                    end
                end
                default: begin
                    state  <= EMPTY;
                    hd_vld <= 1'b0;
                    empty  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_dmw_buf.sv
// Bench for m_dmw_buf: directed vector table, multi-cycle corner sequences, randomized run against a queue model.
module tb_m_dmw_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  DMWop;
    logic [31:0] addr, wdata;
    logic        flush, bus_wready;
    logic        AdES, stall, bus_wvalid, empty;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    m_dmw_buf dut (
        .clk(clk), .reset(reset), .DMWop(DMWop), .addr(addr), .wdata(wdata),
        .flush(flush), .bus_wready(bus_wready), .AdES(AdES), .stall(stall),
        .bus_wvalid(bus_wvalid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .empty(empty)
    );

    always #5 clk = ~clk;

`ifdef DMW_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules written directly from the address map.
    function automatic bit m_ades(input logic [2:0] op, input logic [31:0] a);
        bit legal, timer, count;
        if (op < 3'd1 || op > 3'd3) return 1'b0;
        legal = (a <= 32'h2fff) || (a inside {[32'h7f00:32'h7f0b], [32'h7f10:32'h7f1b], [32'h7f20:32'h7f23]});
        timer = a inside {[32'h7f00:32'h7f0b], [32'h7f10:32'h7f1b]};
        count = a inside {[32'h7f08:32'h7f0b], [32'h7f18:32'h7f1b]};
        if (!legal || count) return 1'b1;
        if (op != 3'd1 && timer) return 1'b1;
        if (op == 3'd1 && (a % 4) != 0) return 1'b1;
        if (op == 3'd2 && (a % 2) != 0) return 1'b1;
        return 1'b0;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    function automatic ent_t m_align(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        e.a = a - (a % 4);
        if (op == 3'd2) begin
            e.d  = 32'(d[15:0]) * 32'h0001_0001;
            e.be = ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
        end else if (op == 3'd3) begin
            e.d  = 32'(d[7:0]) * 32'h0101_0101;
            e.be = 4'(1 << (a % 4));
        end else begin
            e.d  = d;
            e.be = 4'hF;
        end
        return e;
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        logic        ades;
        logic [3:0]  be;
        logic [31:0] data;
    } vec_t;

    vec_t vt[7];
    ent_t q[$];
    ent_t pend_ent, cur, expe;
    bit   pend_pop, pend_push, m_ad, m_req, m_byp, m_vld, m_pop;

    initial begin
        vt[0] = '{3'd3, 32'h0000_2003, 32'hFFFF_FFAB, 1'b0, 4'b1000, 32'hABAB_ABAB};
        vt[1] = '{3'd2, 32'h0000_0002, 32'h0000_BEEF, 1'b0, 4'b1100, 32'hBEEF_BEEF};
        vt[2] = '{3'd2, 32'h0000_7f00, 32'h1111_2222, 1'b1, 4'b0000, 32'h0};
        vt[3] = '{3'd1, 32'h0000_7f08, 32'h3333_4444, 1'b1, 4'b0000, 32'h0};
        vt[4] = '{3'd1, 32'h0000_0001, 32'h5555_6666, 1'b1, 4'b0000, 32'h0};
        vt[5] = '{3'd3, 32'h0000_3000, 32'h7777_8888, 1'b1, 4'b0000, 32'h0};
        vt[6] = '{3'd1, 32'h0000_7f20, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'hCAFE_F00D};

        reset = 1'b0; DMWop = 3'd0; addr = 32'h0; wdata = 32'h0; flush = 1'b0; bus_wready = 1'b0;
        #12;
        chkb("rst_wvalid", bus_wvalid, 1'b0);
        chk ("rst_addr", bus_addr, 32'h0);
        chk ("rst_wdata", bus_wdata, 32'h0);
        chk ("rst_be", 32'(bus_be), 32'h0);
        chkb("rst_empty", empty, 1'b1);
        tick();
        reset = 1'b1;

        // aligned word store with the bridge ready
        tick();
        DMWop = 3'd1; addr = 32'h0000_1004; wdata = 32'h1234_5678; bus_wready = 1'b1;
        #1;
`ifdef DMW_BYPASS_EN
        chkb("sw_byp_vld", bus_wvalid, 1'b1);
        chk ("sw_byp_addr", bus_addr, 32'h1004);
        chk ("sw_byp_be", 32'(bus_be), 32'hF);
        chk ("sw_byp_data", bus_wdata, 32'h1234_5678);
        chkb("sw_byp_empty", empty, 1'b1);
`endif
        tick();
        DMWop = 3'd0;
        #1;
`ifndef DMW_BYPASS_EN
        chkb("sw_vld", bus_wvalid, 1'b1);
        chk ("sw_addr", bus_addr, 32'h1004);
        chk ("sw_be", 32'(bus_be), 32'hF);
        chk ("sw_data", bus_wdata, 32'h1234_5678);
        chkb("sw_empty0", empty, 1'b0);
`endif
        tick();
        chkb("sw_drained", bus_wvalid, 1'b0);
        chkb("sw_empty1", empty, 1'b1);

        // vector table: issue with the bridge stalled, inspect the head, then drain
        for (int i = 0; i < 7; i++) begin
            tick();
            DMWop = vt[i].op; addr = vt[i].a; wdata = vt[i].d; bus_wready = 1'b0;
            #1;
            chkb("vec_ades", AdES, vt[i].ades);
            chkb("vec_stall", stall, 1'b0);
            tick();
            DMWop = 3'd0;
            #1;
            chkb("vec_vld", bus_wvalid, !vt[i].ades);
            chkb("vec_empty", empty, vt[i].ades);
            if (!vt[i].ades) begin
                chk("vec_addr", bus_addr, {vt[i].a[31:2], 2'b00});
                chk("vec_be", 32'(bus_be), 32'(vt[i].be));
                chk("vec_data", bus_wdata, vt[i].data);
                bus_wready = 1'b1;
                tick();
                bus_wready = 1'b0;
                chkb("vec_drain", bus_wvalid, 1'b0);
            end
        end

        // back-pressure: A, B buffered, C stalls until A pops
        tick();
        DMWop = 3'd1; addr = 32'h10; wdata = 32'hAAAA_0001; bus_wready = 1'b0;
        #1; chkb("bp_stall_a", stall, 1'b0);
        tick();
        addr = 32'h14; wdata = 32'hBBBB_0002;
        #1; chkb("bp_stall_b", stall, 1'b0);
        tick();
        addr = 32'h18; wdata = 32'hCCCC_0003;
        #1; chkb("bp_stall_c", stall, 1'b1);
        chk("bp_head_a", bus_wdata, 32'hAAAA_0001);
        tick();
        bus_wready = 1'b1;
        #1; chkb("bp_stall_drop", stall, 1'b0);
        chk("bp_pop_a", bus_wdata, 32'hAAAA_0001);
        tick();
        DMWop = 3'd0;
        #1; chk("bp_pop_b", bus_wdata, 32'hBBBB_0002);
        tick();
        chkb("bp_vld_c", bus_wvalid, 1'b1);
        chk ("bp_pop_c", bus_wdata, 32'hCCCC_0003);
        tick();
        chkb("bp_done", bus_wvalid, 1'b0);
        chkb("bp_empty", empty, 1'b1);

        // flushed store never enters
        tick();
        DMWop = 3'd1; addr = 32'h20; wdata = 32'h0F0F_0F0F; flush = 1'b1; bus_wready = 1'b0;
        #1; chkb("fl_stall", stall, 1'b0);
        tick();
        DMWop = 3'd0; flush = 1'b0;
        chkb("fl_vld", bus_wvalid, 1'b0);
        chkb("fl_empty", empty, 1'b1);

        // asynchronous reset with two entries buffered
        DMWop = 3'd1; addr = 32'h100; wdata = 32'h1;
        tick();
        addr = 32'h104; wdata = 32'h2;
        tick();
        DMWop = 3'd0;
        #1; chkb("ar_full", bus_wvalid, 1'b1);
        #2; reset = 1'b0;
        #1;
        chkb("ar_vld", bus_wvalid, 1'b0);
        chkb("ar_empty", empty, 1'b1);
        chk ("ar_be", 32'(bus_be), 32'h0);
        tick();
        reset = 1'b1;

        // randomized run against the queue model
        pend_pop = 1'b0; pend_push = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (pend_pop) void'(q.pop_front());
            if (pend_push) q.push_back(pend_ent);
            chkb("rnd_empty", empty, q.size() == 0);
            DMWop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: addr = 32'($urandom_range(0, 32'h2fff));
                1: addr = 32'h7f00 + 32'($urandom_range(0, 47));
                2: addr = 32'h2ff0 + 32'($urandom_range(0, 31));
                default: addr = $urandom;
            endcase
            wdata      = $urandom;
            flush      = ($urandom_range(0, 9) == 0);
            bus_wready = ($urandom_range(0, 9) < 6);
            #1;
            m_ad  = m_ades(DMWop, addr);
            m_req = (DMWop >= 3'd1) && (DMWop <= 3'd3) && !m_ad && !flush;
            cur   = m_align(DMWop, addr, wdata);
            m_byp = BYP && (q.size() == 0) && m_req && bus_wready;
            m_vld = m_byp || (q.size() > 0);
            chkb("rnd_ades", AdES, m_ad);
            chkb("rnd_vld", bus_wvalid, m_vld);
            if (m_vld) begin
                expe = m_byp ? cur : q[0];
                chk("rnd_addr", bus_addr, expe.a);
                chk("rnd_data", bus_wdata, expe.d);
                chk("rnd_be", 32'(bus_be), 32'(expe.be));
            end
            m_pop = (q.size() > 0) && bus_wready;
            chkb("rnd_stall", stall, m_req && (q.size() == 2) && !m_pop);
            pend_pop  = m_pop;
            pend_push = m_req && !m_byp && ((q.size() < 2) || m_pop);
            pend_ent  = cur;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
